// File: rtl/friet_rc_pkg.sv
// Shared types and round-constant step functions for the Friet-P round-constant sequencer.
package friet_rc_pkg;

    localparam int unsigned RC_W = 5;

    typedef enum logic {IDLE, RUN} state_e;

    function automatic logic [RC_W-1:0] rc_step_f(input logic [RC_W-1:0] r);
        return {~r[4], r[2], r[1], r[0], r[0] ^ r[3]};
    endfunction

    function automatic logic [RC_W-1:0] rc_step_b(input logic [RC_W-1:0] r);
        return {~r[4], r[0] ^ r[1], r[3], r[2], r[1]};
    endfunction

    function automatic logic [RC_W-1:0] rc_advance(input logic [RC_W-1:0] r, input int unsigned n,
                                                   input logic dir);
        logic [RC_W-1:0] v;
        v = r;
        for (int unsigned i = 0; i < n; i++) begin
            v = dir ? rc_step_b(v) : rc_step_f(v);
        end
        return v;
    endfunction

    // Constant of the last forward round; the inverse direction starts here.
    function automatic logic [RC_W-1:0] rc_final(input logic [RC_W-1:0] init,
                                                 input int unsigned rounds);
        return rc_advance(init, rounds - 1, 1'b0);
    endfunction

endpackage

// File: rtl/friet_rc_step.sv
// One combinational round-constant step, forward (dir_i=0) or inverse (dir_i=1).
module friet_rc_step
    import friet_rc_pkg::*;
(
    input  logic            dir_i,
    input  logic [RC_W-1:0] rc_i,
    output logic [RC_W-1:0] rc_o
);

    always_comb begin
        rc_o = dir_i ? rc_step_b(rc_i) : rc_step_f(rc_i);
    end

endmodule

// File: rtl/friet_rc_sequencer.sv
// Registered round-constant sequencer: emits UNROLL Friet-P round constants per cycle,
// forward or inverse, under control of start/round_en/abort.
module friet_rc_sequencer
    import friet_rc_pkg::*;
#(
    parameter int unsigned     ROUNDS  = 24,
    parameter int unsigned     UNROLL  = 1,
    parameter logic [RC_W-1:0] RC_INIT = 5'b00001,
    localparam int unsigned    CNT_W   = $clog2(ROUNDS + 1)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   inverse,
    input  logic                   abort,
    input  logic                   round_en,
    output logic                   busy,
    output logic [RC_W*UNROLL-1:0] rc_out,
    output logic [CNT_W-1:0]       round_idx,
    output logic                   last,
    output logic                   done
);

    if (UNROLL == 0 || (ROUNDS % UNROLL) != 0) begin : g_bad_unroll
        $error("friet_rc_sequencer: ROUNDS must be a multiple of UNROLL");
    end

    localparam logic [RC_W-1:0]  RC_FINAL = rc_final(RC_INIT, ROUNDS);
    localparam logic [CNT_W-1:0] UNROLL_C = CNT_W'(UNROLL);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(ROUNDS - UNROLL);

    state_e           state_q, state_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // lane[k] is the constant for the k-th round of this cycle; lane[UNROLL] is the next rc_q.
    logic [RC_W-1:0] lane [UNROLL+1];

    assign lane[0] = rc_q;

    for (genvar k = 0; k < UNROLL; k++) begin : g_lane
        friet_rc_step u_step (
            .dir_i (dir_q),
            .rc_i  (lane[k]),
            .rc_o  (lane[k+1])
        );
        assign rc_out[RC_W*k +: RC_W] = lane[k];
    end

    assign busy      = (state_q == RUN);
    assign last      = busy && (cnt_q == LAST_C);
    assign round_idx = cnt_q;
    assign done      = done_q;

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = IDLE;
            rc_d    = RC_INIT;
            dir_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        dir_d   = inverse;
                        rc_d    = inverse ? RC_FINAL : RC_INIT;
                        cnt_d   = '0;
                    end
                end
                RUN: begin
                    if (round_en) begin
                        rc_d  = lane[UNROLL];
                        cnt_d = cnt_q + UNROLL_C;
                        if (last) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            rc_q    <= RC_INIT;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_friet_rc_sequencer.sv
// Bench for friet_rc_sequencer: UNROLL=1 and UNROLL=2 instances share stimulus and are checked
// every cycle against a position-in-sequence model, plus literal spot checks.
module tb_friet_rc_sequencer;

    localparam int unsigned    ROUNDS  = 24;
    localparam logic [4:0]     RC_INIT = 5'b00001;

    logic       clk = 1'b0;
    logic       rstn, start, inverse, abort, round_en;
    logic       busy1, last1, done1, busy2, last2, done2;
    logic [4:0] rc1, idx1, idx2;
    logic [9:0] rc2;

    always #5 clk = ~clk;

    friet_rc_sequencer #(.ROUNDS(ROUNDS), .UNROLL(1), .RC_INIT(RC_INIT)) u_dut1 (
        .clk(clk), .rstn(rstn), .start(start), .inverse(inverse), .abort(abort),
        .round_en(round_en), .busy(busy1), .rc_out(rc1), .round_idx(idx1), .last(last1),
        .done(done1)
    );

    friet_rc_sequencer #(.ROUNDS(ROUNDS), .UNROLL(2), .RC_INIT(RC_INIT)) u_dut2 (
        .clk(clk), .rstn(rstn), .start(start), .inverse(inverse), .abort(abort),
        .round_en(round_en), .busy(busy2), .rc_out(rc2), .round_idx(idx2), .last(last2),
        .done(done2)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [4:0] m_step_f(input logic [4:0] r);
        return {~r[4], r[2], r[1], r[0], r[0] ^ r[3]};
    endfunction

    function automatic logic [4:0] m_step_b(input logic [4:0] r);
        return {~r[4], r[0] ^ r[1], r[3], r[2], r[1]};
    endfunction

    // Constant at forward position j (negative j = steps before RC_INIT).
    function automatic logic [4:0] f_pow(input int j);
        logic [4:0] r;
        r = RC_INIT;
        if (j >= 0) for (int i = 0; i < j; i++) r = m_step_f(r);
        else        for (int i = 0; i < -j; i++) r = m_step_b(r);
        return r;
    endfunction

    function automatic logic [9:0] exp_rc(input bit dir, input int p, input int u);
        logic [9:0] v;
        v = '0;
        for (int k = 0; k < u; k++) begin
            v[5*k +: 5] = dir ? f_pow(int'(ROUNDS) - 1 - p - k) : f_pow(p + k);
        end
        return v;
    endfunction

    // Model: active flag, direction, rounds consumed, done pulse; index 0 -> UNROLL=1, 1 -> 2.
    bit m_act [2];
    bit m_dir [2];
    int m_p   [2];
    bit m_dn  [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rstn || abort) begin
                m_act[i] <= 1'b0;
                m_dir[i] <= 1'b0;
                m_p[i]   <= 0;
                m_dn[i]  <= 1'b0;
            end else if (!m_act[i]) begin
                m_dn[i] <= 1'b0;
                if (start) begin
                    m_act[i] <= 1'b1;
                    m_dir[i] <= inverse;
                    m_p[i]   <= 0;
                end
            end else begin
                m_dn[i] <= 1'b0;
                if (round_en) begin
                    m_p[i] <= m_p[i] + i + 1;
                    if (m_p[i] + i + 1 == int'(ROUNDS)) begin
                        m_act[i] <= 1'b0;
                        m_dn[i]  <= 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy1", busy1, m_act[0]);
            chk("idx1",  idx1,  m_p[0]);
            chk("last1", last1, m_act[0] && m_p[0] == int'(ROUNDS) - 1);
            chk("done1", done1, m_dn[0]);
            chk("rc1",   rc1,   exp_rc(m_dir[0], m_p[0], 1));
            chk("busy2", busy2, m_act[1]);
            chk("idx2",  idx2,  m_p[1]);
            chk("last2", last2, m_act[1] && m_p[1] == int'(ROUNDS) - 2);
            chk("done2", done2, m_dn[1]);
            chk("rc2",   rc2,   exp_rc(m_dir[1], m_p[1], 2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] lit1 [5] = '{5'b00001, 5'b10011, 5'b00111, 5'b11111, 5'b01110};
    logic [9:0] lit2 [2] = '{10'b10011_00001, 10'b11111_00111};

    initial begin
        rstn = 1'b0; start = 1'b0; inverse = 1'b0; abort = 1'b0; round_en = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;
        rstn   = 1'b1;

        for (int x = 0; x < 32; x++) begin
            logic [4:0] r;
            r = 5'(x);
            chk("pkg_step_f", friet_rc_pkg::rc_step_f(r), m_step_f(r));
            chk("pkg_b_then_f", friet_rc_pkg::rc_step_f(friet_rc_pkg::rc_step_b(r)), r);
        end

        // Forward, continuous advance.
        start = 1'b1; round_en = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i < 5) chk("fwd_lit1", rc1, lit1[i]);
            if (i < 2) chk("fwd_lit2", rc2, lit2[i]);
            if (i == 23) chk("fwd_last", last1, 1'b1);
            tick();
        end
        @(negedge clk);
        chk("fwd_done", done1, 1'b1);
        chk("fwd_idle", busy1, 1'b0);
        tick();
        tick();

        // Inverse: must end at RC_INIT.
        start = 1'b1; inverse = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i == 23) chk("inv_end", rc1, 5'b00001);
            tick();
        end
        tick();

        // Stall 5 cycles mid-call, then resume; start pulsed while busy.
        start = 1'b1; inverse = 1'b0; round_en = 1'b1; tick(); start = 1'b0;
        repeat (6) tick();
        round_en = 1'b0;
        repeat (5) tick();
        start = 1'b1; tick(); start = 1'b0;
        round_en = 1'b1;
        repeat (30) tick();

        // Abort at round 7; then start together with abort.
        start = 1'b1; tick(); start = 1'b0;
        repeat (7) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy1, 1'b0);
        chk("abort_rc",   rc1,   5'b00001);
        chk("abort_done", done1, 1'b0);
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("abort_beats_start", busy1, 1'b0);

        // Reset mid-call, then a fresh call.
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        rstn = 1'b0; tick(); rstn = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_idx",  idx1,  5'd0);
        start = 1'b1; tick(); start = 1'b0;
        repeat (30) tick();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            rstn     = ($urandom_range(0, 199) != 0);
            abort    = ($urandom_range(0, 59) == 0);
            start    = ($urandom_range(0, 3) == 0);
            inverse  = 1'($urandom);
            round_en = ($urandom_range(0, 9) < 7);
            tick();
        end
        @(negedge clk);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
